stage4_store_buffer: RTL and testbench

//  Write-side counterpart of the stage-4 load result router: formats integer/FP stores (byte/half/word)

---
 rtl/stage4_store_buffer_pkg.sv | 22 ++
 rtl/store_buffer_fifo.sv | 60 ++++++
 rtl/stage4_store_buffer.sv | 118 +++++++++++
 tb/tb_stage4_store_buffer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/stage4_store_buffer_pkg.sv
// rtl/stage4_store_buffer_pkg.sv - shared encodings, func3 codes and store entry layout
// Purpose: constants and types shared by the stage-4 store buffer and its FIFO.
// Contents: ENCODING_* instruction classes, RV32I store func3 codes,
//           sb_entry_t store entry {addr[31:2], data[31:0], ben[3:0]} and its width.
package stage4_store_buffer_pkg;

    localparam logic [15:0] ENCODING_STORE  = 16'h0010;
    localparam logic [15:0] ENCODING_FSTORE = 16'h0011;

    localparam logic [2:0] RV32I_FUNC3_STORE_BYTE  = 3'b000;
    localparam logic [2:0] RV32I_FUNC3_STORE_HWORD = 3'b001;
    localparam logic [2:0] RV32I_FUNC3_STORE_WORD  = 3'b010;

    localparam int SB_ENTRY_W = 30 + 32 + 4;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  ben;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// rtl/store_buffer_fifo.sv - DEPTH-entry FIFO holding formatted store entries
// Purpose: circular buffer with occupancy count; head entry exposed combinationally.
// Ports: clk, rst (async, active-high), push/push_data, pop,
//        full, empty, head_data (entry at read pointer).
module store_buffer_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int WIDTH = 66
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == (PTR_W + 1)'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];

    // Push is refused when full even if a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is cleared on reset so the head outputs read as zero afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/stage4_store_buffer.sv
// rtl/stage4_store_buffer.sv - stage-4 store formatter and buffered drain to data memory
// Purpose: formats byte/half/word stores into word address, lane-replicated data and byte
//          enables, queues them and drains them over a req/ready handshake.
// Ports: clock_i, reset_i (async, active-high); valid_i, encoding_i, func3_i, addr_i, data_i
//        from stage 3; stall_o, exception_o, empty_o to the pipeline; mem_req_o, mem_addr_o,
//        mem_data_o, mem_ben_o, mem_ready_i toward the data cache.
// Config: STORE_BUFFER_FSTORE_EN - when defined, FP word stores (ENCODING_FSTORE) are accepted.
module stage4_store_buffer
    import stage4_store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        valid_i,
    input  logic [15:0] encoding_i,
    input  logic [2:0]  func3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic        stall_o,
    output logic        exception_o,
    output logic        empty_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic [3:0]  mem_ben_o,
    input  logic        mem_ready_i
);

    logic        is_store;
    logic        is_fstore;
    logic        fmt_ok;
    logic [3:0]  fmt_ben;
    logic [31:0] fmt_data;
    logic        take;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    sb_entry_t   push_entry;
    sb_entry_t   head_entry;

    assign is_store = (encoding_i == ENCODING_STORE);
`ifdef STORE_BUFFER_FSTORE_EN
    assign is_fstore = (encoding_i == ENCODING_FSTORE);
`else
    assign is_fstore = 1'b0;
`endif

    always_comb begin
        fmt_ok   = 1'b0;
        fmt_ben  = 4'b0000;
        fmt_data = data_i;
        case (func3_i)
            RV32I_FUNC3_STORE_BYTE: begin
                fmt_ok   = 1'b1;
                fmt_ben  = 4'b0001 << addr_i[1:0];
                fmt_data = {4{data_i[7:0]}};
            end
            RV32I_FUNC3_STORE_HWORD: begin
                fmt_ok   = !addr_i[0];
                fmt_ben  = addr_i[1] ? 4'b1100 : 4'b0011;
                fmt_data = {2{data_i[15:0]}};
            end
            RV32I_FUNC3_STORE_WORD: begin
                fmt_ok   = (addr_i[1:0] == 2'b00);
                fmt_ben  = 4'b1111;
                fmt_data = data_i;
            end
            default: begin
                fmt_ok = 1'b0;
            end
        endcase
        // FP stores only exist in word width.
        if (is_fstore && (func3_i != RV32I_FUNC3_STORE_WORD)) begin
            fmt_ok = 1'b0;
        end
    end

    // A store is only examined while the buffer can take it; a held store raises no exception.
    assign take = valid_i && (is_store || is_fstore) && !full;
    assign push = take && fmt_ok;
    assign pop  = mem_req_o && mem_ready_i;

    assign push_entry = '{addr: addr_i[31:2], data: fmt_data, ben: fmt_ben};

    store_buffer_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .WIDTH (SB_ENTRY_W)
    ) u_fifo (
        .clk       (clock_i),
        .rst       (reset_i),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head_data (head_entry)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            exception_o <= 1'b0;
        end else begin
            exception_o <= take && !fmt_ok;
        end
    end

    assign stall_o    = full;
    assign empty_o    = empty;
    assign mem_req_o  = !empty;
    assign mem_addr_o = {head_entry.addr, 2'b00};
    assign mem_data_o = head_entry.data;
    assign mem_ben_o  = head_entry.ben;

endmodule

// File: tb/tb_stage4_store_buffer.sv
// tb/tb_stage4_store_buffer.sv - directed self-checking bench for stage4_store_buffer
module tb_stage4_store_buffer;
    import stage4_store_buffer_pkg::*;

    logic        clock_i;
    logic        reset_i;
    logic        valid_i;
    logic [15:0] encoding_i;
    logic [2:0]  func3_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        stall_o;
    logic        exception_o;
    logic        empty_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_ben_o;
    logic        mem_ready_i;

    int vectors;
    int miscompares;

    stage4_store_buffer dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .valid_i     (valid_i),
        .encoding_i  (encoding_i),
        .func3_i     (func3_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .stall_o     (stall_o),
        .exception_o (exception_o),
        .empty_o     (empty_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_ben_o   (mem_ben_o),
        .mem_ready_i (mem_ready_i)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic store(input logic [15:0] enc, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        valid_i    = 1'b1;
        encoding_i = enc;
        func3_i    = f3;
        addr_i     = a;
        data_i     = d;
        tick();
        valid_i    = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_i     = 1'b1;
        valid_i     = 1'b0;
        encoding_i  = 16'h0000;
        func3_i     = 3'b000;
        addr_i      = 32'h0;
        data_i      = 32'h0;
        mem_ready_i = 1'b0;
        tick();
        tick();
        check("rst_stall", stall_o, 0);
        check("rst_exc", exception_o, 0);
        check("rst_empty", empty_o, 1);
        check("rst_req", mem_req_o, 0);
        check("rst_addr", mem_addr_o, 32'h0);
        check("rst_data", mem_data_o, 32'h0);
        check("rst_ben", mem_ben_o, 0);
        reset_i = 1'b0;
        tick();

        // SW aligned, retires immediately with ready high
        mem_ready_i = 1'b1;
        store(ENCODING_STORE, RV32I_FUNC3_STORE_WORD, 32'h100, 32'hDEADBEEF);
        check("sw_req", mem_req_o, 1);
        check("sw_addr", mem_addr_o, 32'h100);
        check("sw_data", mem_data_o, 32'hDEADBEEF);
        check("sw_ben", mem_ben_o, 4'hF);
        check("sw_empty", empty_o, 0);
        tick();
        check("sw_retired_empty", empty_o, 1);
        check("sw_retired_req", mem_req_o, 0);

        // SB and SH lane formatting
        mem_ready_i = 1'b0;
        store(ENCODING_STORE, RV32I_FUNC3_STORE_BYTE, 32'h203, 32'h00000055);
        check("sb_addr", mem_addr_o, 32'h200);
        check("sb_data", mem_data_o, 32'h55555555);
        check("sb_ben", mem_ben_o, 4'b1000);
        mem_ready_i = 1'b1;
        tick();
        check("sb_retired", empty_o, 1);
        mem_ready_i = 1'b0;
        store(ENCODING_STORE, RV32I_FUNC3_STORE_HWORD, 32'h202, 32'h00001234);
        check("sh_addr", mem_addr_o, 32'h200);
        check("sh_data", mem_data_o, 32'h12341234);
        check("sh_ben", mem_ben_o, 4'b1100);
        mem_ready_i = 1'b1;
        tick();
        check("sh_retired", empty_o, 1);
        mem_ready_i = 1'b0;

        // Misaligned and unknown-func3 stores: one-cycle exception, nothing queued
        store(ENCODING_STORE, RV32I_FUNC3_STORE_HWORD, 32'h101, 32'h1);
        check("sh_mis_exc", exception_o, 1);
        check("sh_mis_empty", empty_o, 1);
        tick();
        check("sh_mis_exc_drop", exception_o, 0);
        store(ENCODING_STORE, RV32I_FUNC3_STORE_WORD, 32'h102, 32'h2);
        check("sw_mis_exc", exception_o, 1);
        check("sw_mis_empty", empty_o, 1);
        tick();
        check("sw_mis_exc_drop", exception_o, 0);
        store(ENCODING_STORE, 3'b011, 32'h100, 32'h3);
        check("f3_bad_exc", exception_o, 1);
        check("f3_bad_empty", empty_o, 1);
        tick();
        check("f3_bad_exc_drop", exception_o, 0);

        // Fill to full with ready low, fifth store held by stall
        store(ENCODING_STORE, RV32I_FUNC3_STORE_WORD, 32'h300, 32'hA0);
        check("fill0_stall", stall_o, 0);
        store(ENCODING_STORE, RV32I_FUNC3_STORE_WORD, 32'h304, 32'hA1);
        check("fill1_stall", stall_o, 0);
        store(ENCODING_STORE, RV32I_FUNC3_STORE_WORD, 32'h308, 32'hA2);
        check("fill2_stall", stall_o, 0);
        store(ENCODING_STORE, RV32I_FUNC3_STORE_WORD, 32'h30C, 32'hA3);
        check("fill3_stall", stall_o, 1);
        valid_i    = 1'b1;
        encoding_i = ENCODING_STORE;
        func3_i    = RV32I_FUNC3_STORE_WORD;
        addr_i     = 32'h310;
        data_i     = 32'hA4;
        tick();
        check("full_stall_held", stall_o, 1);
        check("full_head_stable", mem_data_o, 32'hA0);
        check("full_addr_stable", mem_addr_o, 32'h300);
        check("full_no_exc", exception_o, 0);
        mem_ready_i = 1'b1;
        tick();
        check("drain_a1", mem_data_o, 32'hA1);
        check("drain_unstall", stall_o, 0);
        tick();
        valid_i = 1'b0;
        check("drain_a2", mem_data_o, 32'hA2);
        tick();
        check("drain_a3", mem_data_o, 32'hA3);
        tick();
        check("drain_a4", mem_data_o, 32'hA4);
        check("drain_a4_addr", mem_addr_o, 32'h310);
        tick();
        check("drain_empty", empty_o, 1);
        mem_ready_i = 1'b0;

        // Concurrent push and pop with two entries held, across pointer wrap
        store(ENCODING_STORE, RV32I_FUNC3_STORE_WORD, 32'h500, 32'hB0);
        store(ENCODING_STORE, RV32I_FUNC3_STORE_WORD, 32'h504, 32'hB1);
        mem_ready_i = 1'b1;
        store(ENCODING_STORE, RV32I_FUNC3_STORE_WORD, 32'h508, 32'hB2);
        check("pp_head_b1", mem_data_o, 32'hB1);
        check("pp_stall0", stall_o, 0);
        store(ENCODING_STORE, RV32I_FUNC3_STORE_WORD, 32'h50C, 32'hB3);
        check("pp_head_b2", mem_data_o, 32'hB2);
        store(ENCODING_STORE, RV32I_FUNC3_STORE_WORD, 32'h510, 32'hB4);
        check("pp_head_b3", mem_data_o, 32'hB3);
        check("pp_stall1", stall_o, 0);
        tick();
        check("pp_head_b4", mem_data_o, 32'hB4);
        tick();
        check("pp_empty", empty_o, 1);
        mem_ready_i = 1'b0;

        // Asynchronous reset in the middle of a stalled handshake
        store(ENCODING_STORE, RV32I_FUNC3_STORE_WORD, 32'h600, 32'hC0);
        store(ENCODING_STORE, RV32I_FUNC3_STORE_WORD, 32'h604, 32'hC1);
        store(ENCODING_STORE, RV32I_FUNC3_STORE_WORD, 32'h608, 32'hC2);
        check("pre_rst_req", mem_req_o, 1);
        #2;
        reset_i = 1'b1;
        #1;
        check("arst_empty", empty_o, 1);
        check("arst_req", mem_req_o, 0);
        check("arst_addr", mem_addr_o, 32'h0);
        check("arst_data", mem_data_o, 32'h0);
        check("arst_stall", stall_o, 0);
        reset_i = 1'b0;
        tick();
        check("post_rst_empty", empty_o, 1);

        // FP store handling depends on the build option
        store(ENCODING_FSTORE, RV32I_FUNC3_STORE_WORD, 32'h400, 32'hF00DF00D);
`ifdef STORE_BUFFER_FSTORE_EN
        check("fsw_req", mem_req_o, 1);
        check("fsw_data", mem_data_o, 32'hF00DF00D);
        check("fsw_ben", mem_ben_o, 4'hF);
`else
        check("fsw_ignored", empty_o, 1);
`endif
        check("fsw_exc", exception_o, 0);
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        store(ENCODING_FSTORE, RV32I_FUNC3_STORE_BYTE, 32'h400, 32'h1);
`ifdef STORE_BUFFER_FSTORE_EN
        check("fsb_exc", exception_o, 1);
`else
        check("fsb_exc", exception_o, 0);
`endif
        check("fsb_empty", empty_o, 1);
        store(16'h0001, RV32I_FUNC3_STORE_WORD, 32'h400, 32'h2);
        check("other_enc_empty", empty_o, 1);
        check("other_enc_exc", exception_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
